// File: rtl/ipsl_hmic_h_ddrc_apb_arbiter_v1_1.sv
// Round-robin arbiter sharing the DDRC APB config port between the init sequencer (req0)
// and runtime register access (req1); one registered APB transfer at a time with pready timeout.
module ipsl_hmic_h_ddrc_apb_arbiter_v1_1 #(
  parameter logic [15:0] TIMEOUT = 16'd1024,
  parameter int          ADDR_W  = 12,
  parameter int          DATA_W  = 32
) (
  input  logic              pclk,
  input  logic              resetn,
  input  logic              lock0,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_done,
  output logic              req0_err,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_done,
  output logic              req1_err,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_rr_last;
  logic                r_gnt;
  logic [15:0]         r_cnt;
  logic                r_psel;
  logic                r_penable;
  logic                r_pwrite;
  logic [ADDR_W-1:0]   r_paddr;
  logic [DATA_W-1:0]   r_pwdata;
  logic                r_busy;
  logic                r_req0_done;
  logic                r_req0_err;
  logic [DATA_W-1:0]   r_req0_rdata;
  logic                r_req1_done;
  logic                r_req1_err;
  logic [DATA_W-1:0]   r_req1_rdata;

  logic                w_elig1;
  logic                w_gnt_vld;
  logic                w_gnt_sel;
  logic                w_timeout;
  logic                w_access_end;

  assign w_elig1      = req1_valid & ~lock0;
  assign w_timeout    = (TIMEOUT != 16'd0) && (r_cnt == (TIMEOUT - 16'd1));
  assign w_access_end = pready | w_timeout;

  // On a tie the requester that did not finish last wins.
  always_comb begin
    w_gnt_vld = req0_valid | w_elig1;
    w_gnt_sel = 1'b0;
    if (req0_valid && w_elig1) begin
      w_gnt_sel = ~r_rr_last;
    end else if (w_elig1) begin
      w_gnt_sel = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_gnt_vld) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (w_access_end) w_state_nxt = ST_DONE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      r_rr_last    <= 1'b1;
      r_gnt        <= 1'b0;
      r_cnt        <= 16'd0;
      r_psel       <= 1'b0;
      r_penable    <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pwdata     <= '0;
      r_busy       <= 1'b0;
      r_req0_done  <= 1'b0;
      r_req0_err   <= 1'b0;
      r_req0_rdata <= '0;
      r_req1_done  <= 1'b0;
      r_req1_err   <= 1'b0;
      r_req1_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_gnt    <= w_gnt_sel;
            r_pwrite <= w_gnt_sel ? req1_write : req0_write;
            r_paddr  <= w_gnt_sel ? req1_addr  : req0_addr;
            r_pwdata <= w_gnt_sel ? req1_wdata : req0_wdata;
            r_psel   <= 1'b1;
            r_busy   <= 1'b1;
            r_cnt    <= 16'd0;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
        end
        ST_ACCESS: begin
          r_cnt <= r_cnt + 16'd1;
          if (w_access_end) begin
            // pready has priority: a ready on the timeout cycle still completes cleanly.
            r_psel       <= 1'b0;
            r_penable    <= 1'b0;
            r_rr_last    <= r_gnt;
            r_req0_done  <= ~r_gnt;
            r_req1_done  <= r_gnt;
            r_req0_err   <= ~r_gnt & ~pready;
            r_req1_err   <= r_gnt & ~pready;
            r_req0_rdata <= (~r_gnt && pready && !r_pwrite) ? prdata : '0;
            r_req1_rdata <= (r_gnt && pready && !r_pwrite) ? prdata : '0;
          end
        end
        ST_DONE: begin
          r_busy       <= 1'b0;
          r_req0_done  <= 1'b0;
          r_req0_err   <= 1'b0;
          r_req0_rdata <= '0;
          r_req1_done  <= 1'b0;
          r_req1_err   <= 1'b0;
          r_req1_rdata <= '0;
        end
        default: ;
      endcase
    end
  end

  assign psel       = r_psel;
  assign penable    = r_penable;
  assign pwrite     = r_pwrite;
  assign paddr      = r_paddr;
  assign pwdata     = r_pwdata;
  assign busy       = r_busy;
  assign req0_done  = r_req0_done;
  assign req0_err   = r_req0_err;
  assign req0_rdata = r_req0_rdata;
  assign req1_done  = r_req1_done;
  assign req1_err   = r_req1_err;
  assign req1_rdata = r_req1_rdata;

endmodule
